// File: rtl/noc_mux2_flit_if.sv
// Flit link bundle for the 2:1 output mux: two input flit streams, port select, and the registered output.
interface noc_mux2_flit_if #(
    parameter int DATAW = 66,
    parameter int VCHW  = 2,
    parameter int PORTW = 5
);
    logic [DATAW-1:0] idata_0;
    logic             ivalid_0;
    logic [VCHW-1:0]  ivch_0;
    logic [DATAW-1:0] idata_1;
    logic             ivalid_1;
    logic [VCHW-1:0]  ivch_1;
    logic [PORTW-1:0] sel;
    logic [DATAW-1:0] odata;
    logic             ovalid;
    logic [VCHW-1:0]  ovch;

    modport master (
        output idata_0, ivalid_0, ivch_0, idata_1, ivalid_1, ivch_1, sel,
        input  odata, ovalid, ovch
    );

    modport slave (
        input  idata_0, ivalid_0, ivch_0, idata_1, ivalid_1, ivch_1, sel,
        output odata, ovalid, ovch
    );
endinterface

// File: rtl/noc_mux2_flit.sv
// 2:1 flit mux for one router output link. Grant locks from HEAD to TAIL;
// the output is registered and zero-gated whenever no valid flit is forwarded.
module noc_mux2_flit #(
    parameter int DATAW = 66,
    parameter int VCHW  = 2,
    parameter int PORTW = 5,
    parameter int TYPEW = 2
) (
    input logic           clk,
    input logic           rst_,
    noc_mux2_flit_if.slave bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
    localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(3);

    state_t           state;
    logic [1:0]       grant_q;
    logic [1:0]       sel_dec;
    logic [1:0]       grant;
    logic             g_valid;
    logic [DATAW-1:0] g_data;
    logic [VCHW-1:0]  g_vch;
    logic [TYPEW-1:0] g_type;
    logic [DATAW-1:0] odata_q;
    logic             ovalid_q;
    logic [VCHW-1:0]  ovch_q;
    logic             unused_sel;

    // Only the two low select bits name real inputs; bit 0 wins a tie.
    assign unused_sel = ^bus.sel[PORTW-1:2];

    always_comb begin
        sel_dec = 2'b00;
        if (bus.sel[0])      sel_dec = 2'b01;
        else if (bus.sel[1]) sel_dec = 2'b10;
    end

    assign grant = (state == LOCKED) ? grant_q : sel_dec;

    always_comb begin
        g_valid = 1'b0;
        g_data  = '0;
        g_vch   = '0;
        if (grant[0]) begin
            g_valid = bus.ivalid_0;
            g_data  = bus.idata_0;
            g_vch   = bus.ivch_0;
        end else if (grant[1]) begin
            g_valid = bus.ivalid_1;
            g_data  = bus.idata_1;
            g_vch   = bus.ivch_1;
        end
    end

    assign g_type = g_data[DATAW-1 -: TYPEW];

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= IDLE;
            grant_q  <= 2'b00;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            ovch_q   <= '0;
        end else begin
            ovalid_q <= g_valid;
            odata_q  <= g_valid ? g_data : '0;
            ovch_q   <= g_valid ? g_vch : '0;
            case (state)
                IDLE: begin
                    if (g_valid && g_type == T_HEAD) begin
                        state   <= LOCKED;
                        grant_q <= sel_dec;
                    end
                end
                LOCKED: begin
                    // A gap on the granted input is treated as an abort and frees the link.
                    if (!g_valid || g_type == T_TAIL) begin
                        state   <= IDLE;
                        grant_q <= 2'b00;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign bus.odata  = odata_q;
    assign bus.ovalid = ovalid_q;
    assign bus.ovch   = ovch_q;
endmodule

// File: tb/tb_noc_mux2_flit.sv
// Directed bench for noc_mux2_flit: forwarding, packet lock, gating, select priority, abort and async reset.
module tb_noc_mux2_flit;
    localparam int DATAW = 66;
    localparam int VCHW  = 2;
    localparam int PORTW = 5;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_DATA = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    noc_mux2_flit_if #(.DATAW(DATAW), .VCHW(VCHW), .PORTW(PORTW)) bus ();

    noc_mux2_flit #(.DATAW(DATAW), .VCHW(VCHW), .PORTW(PORTW), .TYPEW(2)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    function automatic logic [DATAW-1:0] fl(input logic [1:0] t, input logic [63:0] p);
        return {t, p};
    endfunction

    task automatic chk(input string tag, input logic [DATAW-1:0] got, input logic [DATAW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [DATAW-1:0] ed,
                           input logic [VCHW-1:0] ec);
        chk({tag, ".ovalid"}, DATAW'(bus.ovalid), DATAW'(ev));
        chk({tag, ".odata"},  bus.odata, ed);
        chk({tag, ".ovch"},   DATAW'(bus.ovch), DATAW'(ec));
    endtask

    task automatic drv(input logic [PORTW-1:0] s,
                       input logic v0, input logic [DATAW-1:0] d0, input logic [VCHW-1:0] c0,
                       input logic v1, input logic [DATAW-1:0] d1, input logic [VCHW-1:0] c1);
        bus.sel      = s;
        bus.ivalid_0 = v0; bus.idata_0 = d0; bus.ivch_0 = c0;
        bus.ivalid_1 = v1; bus.idata_1 = d1; bus.ivch_1 = c1;
    endtask

    task automatic step(input string tag, input logic ev, input logic [DATAW-1:0] ed,
                        input logic [VCHW-1:0] ec);
        @(posedge clk);
        #1;
        chk_out(tag, ev, ed, ec);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    initial begin
        drv(5'b00000, 1'b0, '0, '0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, '0, 2'd0);
        rst_ = 1'b1;

        // Basic forward on input 1 while input 0 streams junk.
        drv(5'b00010, 1'b1, fl(T_DATA, 64'hAAAA), 2'd1, 1'b1, fl(T_HEAD, {32'h0, 32'h4}), 2'd2);
        step("fwd_head", 1'b1, fl(T_HEAD, {32'h0, 32'h4}), 2'd2);
        for (int i = 0; i < 20; i++) begin
            drv(5'b00010, 1'b1, fl(T_DATA, 64'hAAAA), 2'd1, 1'b1, fl(T_DATA, 64'h100 + 64'(i)), 2'd2);
            step("fwd_data", 1'b1, fl(T_DATA, 64'h100 + 64'(i)), 2'd2);
        end
        drv(5'b00010, 1'b1, fl(T_DATA, 64'hAAAA), 2'd1, 1'b1, fl(T_TAIL, 64'hF00D), 2'd2);
        step("fwd_tail", 1'b1, fl(T_TAIL, 64'hF00D), 2'd2);
        drv(5'b00010, 1'b1, fl(T_DATA, 64'hAAAA), 2'd1, 1'b0, fl(T_DATA, 64'h5), 2'd2);
        step("fwd_after", 1'b0, '0, 2'd0);

        // Idle gating: data toggles with valid low.
        for (int i = 0; i < 4; i++) begin
            drv(5'b00010, 1'b0, '0, 2'd0, 1'b0,
                (i % 2 == 0) ? {DATAW{1'b1}} : fl(T_HEAD, 64'h5555_5555_5555_5555), 2'd3);
            step("gate", 1'b0, '0, 2'd0);
        end

        // Lock: sel moves to input 0 mid-packet; input 1 keeps the link through TAIL.
        drv(5'b00010, 1'b0, '0, 2'd0, 1'b1, fl(T_HEAD, 64'h11), 2'd1);
        step("lock_head", 1'b1, fl(T_HEAD, 64'h11), 2'd1);
        for (int i = 0; i < 3; i++) begin
            drv(5'b00010, 1'b0, '0, 2'd0, 1'b1, fl(T_DATA, 64'h20 + 64'(i)), 2'd1);
            step("lock_data", 1'b1, fl(T_DATA, 64'h20 + 64'(i)), 2'd1);
        end
        drv(5'b00001, 1'b1, fl(T_HEAD, 64'h99), 2'd3, 1'b1, fl(T_DATA, 64'h30), 2'd1);
        step("lock_hold", 1'b1, fl(T_DATA, 64'h30), 2'd1);
        drv(5'b00001, 1'b1, fl(T_HEAD, 64'h99), 2'd3, 1'b1, fl(T_TAIL, 64'h31), 2'd1);
        step("lock_tail", 1'b1, fl(T_TAIL, 64'h31), 2'd1);
        drv(5'b00001, 1'b1, fl(T_HEAD, 64'h99), 2'd3, 1'b1, fl(T_DATA, 64'h32), 2'd1);
        step("lock_next_head", 1'b1, fl(T_HEAD, 64'h99), 2'd3);
        drv(5'b00001, 1'b1, fl(T_TAIL, 64'h9A), 2'd3, 1'b0, '0, 2'd0);
        step("lock_next_tail", 1'b1, fl(T_TAIL, 64'h9A), 2'd3);

        // Select priority and invalid selects.
        drv(5'b00011, 1'b1, fl(T_DATA, 64'h0A), 2'd1, 1'b1, fl(T_DATA, 64'h1B), 2'd3);
        step("prio_both", 1'b1, fl(T_DATA, 64'h0A), 2'd1);
        drv(5'b00000, 1'b1, fl(T_DATA, 64'h0A), 2'd1, 1'b1, fl(T_DATA, 64'h1B), 2'd3);
        step("sel_none", 1'b0, '0, 2'd0);
        drv(5'b11100, 1'b1, fl(T_DATA, 64'h0A), 2'd1, 1'b1, fl(T_DATA, 64'h1B), 2'd3);
        step("sel_high", 1'b0, '0, 2'd0);
        drv(5'b11110, 1'b1, fl(T_DATA, 64'h0A), 2'd1, 1'b1, fl(T_NONE, 64'h1C), 2'd3);
        step("sel_hi_in1", 1'b1, fl(T_NONE, 64'h1C), 2'd3);

        // One-cycle HEAD then TAIL; sel switched on the TAIL cycle takes effect after it.
        drv(5'b00010, 1'b0, '0, 2'd0, 1'b1, fl(T_HEAD, 64'h40), 2'd1);
        step("ht_head", 1'b1, fl(T_HEAD, 64'h40), 2'd1);
        drv(5'b00001, 1'b1, fl(T_DATA, 64'h50), 2'd2, 1'b1, fl(T_TAIL, 64'h41), 2'd1);
        step("ht_tail", 1'b1, fl(T_TAIL, 64'h41), 2'd1);
        drv(5'b00001, 1'b1, fl(T_DATA, 64'h51), 2'd2, 1'b1, fl(T_DATA, 64'h42), 2'd1);
        step("ht_newsel", 1'b1, fl(T_DATA, 64'h51), 2'd2);

        // Abort: granted valid drops mid-packet; new sel honoured the cycle after.
        drv(5'b00001, 1'b1, fl(T_HEAD, 64'h60), 2'd3, 1'b0, '0, 2'd0);
        step("abort_head", 1'b1, fl(T_HEAD, 64'h60), 2'd3);
        drv(5'b00001, 1'b1, fl(T_DATA, 64'h61), 2'd3, 1'b0, '0, 2'd0);
        step("abort_data", 1'b1, fl(T_DATA, 64'h61), 2'd3);
        drv(5'b00010, 1'b0, fl(T_DATA, 64'h62), 2'd3, 1'b1, fl(T_DATA, 64'h70), 2'd1);
        step("abort_gap", 1'b0, '0, 2'd0);
        drv(5'b00010, 1'b1, fl(T_DATA, 64'h63), 2'd3, 1'b1, fl(T_DATA, 64'h71), 2'd1);
        step("abort_newsel", 1'b1, fl(T_DATA, 64'h71), 2'd1);

        // Asynchronous reset mid-packet, then restart in IDLE.
        drv(5'b00001, 1'b1, fl(T_HEAD, 64'h80), 2'd2, 1'b0, '0, 2'd0);
        step("rst_pre", 1'b1, fl(T_HEAD, 64'h80), 2'd2);
        #2 rst_ = 1'b0;
        #1 chk_out("rst_async", 1'b0, '0, 2'd0);
        #3 rst_ = 1'b1;
        drv(5'b00010, 1'b1, fl(T_DATA, 64'h81), 2'd2, 1'b1, fl(T_DATA, 64'h90), 2'd2);
        step("rst_restart", 1'b1, fl(T_DATA, 64'h90), 2'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/noc_mux2_flit.md
Name: noc_mux2_flit

Overview:
- 2:1 flit multiplexer for one NoC router output link.
- Forwards one of two input flit streams (data, valid, virtual channel) to a single output, chosen by a one-hot port-select word.
- Selection locks per packet, from head flit to tail flit, so packets never interleave.
- Output is registered to give a clean, glitch-free boundary for energy characterisation; idle outputs are zero-gated to suppress toggling.

Parameters:
- DATAW, 66: flit width = 2-bit type field (MSBs) + 64-bit payload.
- VCHW, 2: virtual-channel id width.
- PORTW, 5: port-select width. Only bits 0 and 1 are used.
- TYPEW, 2: flit type field width (odata[DATAW-1:DATAW-TYPEW]).

Ports:
- clk  in  1  clock, rising edge.
- rst_  in  1  asynchronous active-low reset.
- idata_0  in  DATAW  input 0 flit.
- ivalid_0  in  1  input 0 flit valid.
- ivch_0  in  VCHW  input 0 VC id.
- idata_1  in  DATAW  input 1 flit.
- ivalid_1  in  1  input 1 flit valid.
- ivch_1  in  VCHW  input 1 VC id.
- sel  in  PORTW  one-hot select: bit0 selects input 0, bit1 selects input 1.
- odata  out  DATAW  forwarded flit (registered).
- ovalid  out  1  forwarded valid (registered).
- ovch  out  VCHW  forwarded VC id (registered).

Behaviour:
- Flit types (top TYPEW bits): NONE=00, HEAD=01, DATA=10, TAIL=11.
- Reset (rst_=0, asynchronous): odata=0, ovalid=0, ovch=0, FSM=IDLE, grant=none. Takes effect immediately, including mid-packet. After release, the block restarts in IDLE.
- Select decode: sel[0]=1 -> input 0 (wins if sel[0] and sel[1] are both 1). Else sel[1]=1 -> input 1. Else no selection. sel[PORTW-1:2] ignored.
- FSM states:
  - IDLE: grant follows decoded sel, combinationally, every cycle. If the selected ivalid=1 and its type=HEAD, latch grant and go to LOCKED the next cycle. If the selected ivalid=1 and the flit is not HEAD, it is still forwarded and the FSM stays IDLE.
  - LOCKED: grant frozen; sel ignored. Return to IDLE after the cycle in which the granted input presents ivalid=1 with type=TAIL. Also return to IDLE after any cycle in which the granted ivalid=0 (abort).
- Datapath: each rising edge,
  - ovalid <= ivalid of granted input (0 if no grant).
  - odata/ovch <= granted idata/ivch when that ivalid=1, else all zeros.
- Latency: exactly 1 cycle from input to output. No backpressure and no buffering; every valid flit on the granted input appears exactly once.
- Non-granted input: ignored and dropped.
- Payload: passed bit-exact; no checking of type sequence beyond HEAD/TAIL detection.
- Single-cycle HEAD followed by immediate TAIL is legal: LOCKED for one cycle, then IDLE.
- sel change on the same edge as a TAIL: the new sel applies from the following cycle (IDLE decode).

Test Plan:
- Reset: assert rst_=0 mid-stream with ovalid=1 -> odata=0, ovalid=0, ovch=0 immediately, without waiting for a clock edge.
- Basic forward: sel=5'b00010; input 1 sends HEAD {01,32'h0,32'h04}, 20 DATA flits, then TAIL, with ivch_1=2 -> identical flits on odata one cycle later, ovalid=1 for 22 cycles, ovch=2. Input 0 traffic never appears.
- Lock: during input-1 packet, switch sel to 5'b00001 after 3 DATA flits -> output continues input-1 flits through TAIL. The next input-0 HEAD is forwarded afterwards.
- Idle gating: sel=5'b00010, ivalid_1=0, idata_1 toggling -> odata stays 0, ovalid=0.
- Priority/invalid sel: sel=5'b00011 -> input 0 forwarded. sel=5'b00000 or 5'b11100 -> ovalid=0, odata=0.
- Abort: granted ivalid drops mid-packet -> next cycle ovalid=0, FSM IDLE, new sel honoured.
